// File: rtl/rom_read_arbiter_if.sv
// Request/return bundle between the two ROM requesters, the arbiter and the
// ROM read port. The arbiter uses the slave view; the requesters and the ROM
// model (together) use the master view.
interface rom_read_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    // Port A (CPU fetch)
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_ack;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    // Port B (video/DMA)
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic              b_ack;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    // ROM read port
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;

    modport slave (
        input  a_req, a_addr, b_req, b_addr, rom_q,
        output a_ack, a_rvalid, a_rdata,
        output b_ack, b_rvalid, b_rdata,
        output rom_addr
    );

    modport master (
        output a_req, a_addr, b_req, b_addr, rom_q,
        input  a_ack, a_rvalid, a_rdata,
        input  b_ack, b_rvalid, b_rdata,
        input  rom_addr
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Two-port read arbiter in front of a single synchronous-read program ROM.
// One requester is granted per cycle (round-robin or fixed priority with a
// starvation guard); each grant is tagged and the ROM data is steered back to
// the winner exactly two cycles after its ack, in grant order.
module rom_read_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int PRIO_MODE  = 0,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    rom_read_arbiter_if.slave   bus
);

    localparam logic [3:0] STARVE_W = 4'(STARVE_MAX);
    localparam logic [3:0] WAIT_SAT = 4'hF;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Arbitration state
    port_e             rr_last_q, rr_last_d;
    logic [3:0]        b_wait_q,  b_wait_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;

    // Return pipeline: tag for the access currently being read by the ROM
    logic              tag_vld_q, tag_vld_d;
    port_e             tag_id_q,  tag_id_d;

    // Registered return outputs
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q,  a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q,  b_rdata_d;

    // Combinational grant
    logic              a_win_s, b_win_s, grant_s;
    logic [ADDR_W-1:0] rom_addr_s;

    // Pick this cycle's winner; nothing is granted while reset is held
    always_comb begin
        a_win_s = 1'b0;
        b_win_s = 1'b0;
        if (rst) begin
            a_win_s = 1'b0;
            b_win_s = 1'b0;
        end else if (PRIO_MODE == 1) begin
            // Fixed priority to A, but a B that has waited STARVE_MAX cycles goes next
            if (bus.b_req && (b_wait_q == STARVE_W)) begin
                b_win_s = 1'b1;
            end else if (bus.a_req) begin
                a_win_s = 1'b1;
            end else if (bus.b_req) begin
                b_win_s = 1'b1;
            end else begin
                a_win_s = 1'b0;
            end
        end else begin
            // Round-robin: on contention the side that did not win last time wins
            if (bus.a_req && bus.b_req) begin
                if (rr_last_q == PORT_B) begin
                    a_win_s = 1'b1;
                end else begin
                    b_win_s = 1'b1;
                end
            end else if (bus.a_req) begin
                a_win_s = 1'b1;
            end else if (bus.b_req) begin
                b_win_s = 1'b1;
            end else begin
                a_win_s = 1'b0;
            end
        end
    end

    // ROM address mux; idle cycles hold the last granted address to avoid toggling
    always_comb begin
        grant_s    = a_win_s | b_win_s;
        rom_addr_s = last_addr_q;
        if (a_win_s) begin
            rom_addr_s = bus.a_addr;
        end else if (b_win_s) begin
            rom_addr_s = bus.b_addr;
        end else begin
            rom_addr_s = last_addr_q;
        end
    end

    // Next state of arbitration history and starvation counter
    always_comb begin
        last_addr_d = rom_addr_s;
        rr_last_d   = rr_last_q;
        b_wait_d    = b_wait_q;
        if (grant_s) begin
            rr_last_d = b_win_s ? PORT_B : PORT_A;
        end else begin
            rr_last_d = rr_last_q;
        end
        if (!bus.b_req || b_win_s) begin
            b_wait_d = 4'd0;
        end else if (b_wait_q != WAIT_SAT) begin
            b_wait_d = b_wait_q + 4'd1;
        end else begin
            b_wait_d = b_wait_q;
        end
    end

    // Return pipeline: tag the grant, then steer the ROM output to the tagged port
    always_comb begin
        tag_vld_d  = grant_s;
        tag_id_d   = b_win_s ? PORT_B : PORT_A;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        if (tag_vld_q) begin
            if (tag_id_q == PORT_B) begin
                b_rvalid_d = 1'b1;
                b_rdata_d  = bus.rom_q;
            end else begin
                a_rvalid_d = 1'b1;
                a_rdata_d  = bus.rom_q;
            end
        end else begin
            a_rvalid_d = 1'b0;
            b_rvalid_d = 1'b0;
        end
    end

    // State registers; reset discards in-flight tags and arbitration history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q   <= PORT_B;
            b_wait_q    <= 4'd0;
            last_addr_q <= '0;
            tag_vld_q   <= 1'b0;
            tag_id_q    <= PORT_A;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            rr_last_q   <= rr_last_d;
            b_wait_q    <= b_wait_d;
            last_addr_q <= last_addr_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign bus.a_ack    = a_win_s;
    assign bus.b_ack    = b_win_s;
    assign bus.rom_addr = rom_addr_s;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter. Two instances run side by side:
// inst 0 in round-robin mode, inst 1 in fixed-priority mode (STARVE_MAX=3).
// Stimulus pushes the expected data and due cycle at each expected grant;
// a negedge monitor pops and compares whenever an rvalid appears.
module tb_rom_read_arbiter;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rom_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
    rom_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

    rom_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(0), .STARVE_MAX(3))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    rom_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(1), .STARVE_MAX(3))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // Per-instance drive / observe arrays
    logic              a_req_s [2];
    logic              b_req_s [2];
    logic [ADDR_W-1:0] a_addr_s[2];
    logic [ADDR_W-1:0] b_addr_s[2];
    logic              a_ack_s [2];
    logic              b_ack_s [2];
    logic              a_rv_s  [2];
    logic              b_rv_s  [2];
    logic [DATA_W-1:0] a_rd_s  [2];
    logic [DATA_W-1:0] b_rd_s  [2];
    logic [ADDR_W-1:0] rom_a_s [2];

    assign bus0.a_req  = a_req_s[0];
    assign bus0.b_req  = b_req_s[0];
    assign bus0.a_addr = a_addr_s[0];
    assign bus0.b_addr = b_addr_s[0];
    assign bus1.a_req  = a_req_s[1];
    assign bus1.b_req  = b_req_s[1];
    assign bus1.a_addr = a_addr_s[1];
    assign bus1.b_addr = b_addr_s[1];
    assign a_ack_s[0] = bus0.a_ack;    assign a_ack_s[1] = bus1.a_ack;
    assign b_ack_s[0] = bus0.b_ack;    assign b_ack_s[1] = bus1.b_ack;
    assign a_rv_s[0]  = bus0.a_rvalid; assign a_rv_s[1]  = bus1.a_rvalid;
    assign b_rv_s[0]  = bus0.b_rvalid; assign b_rv_s[1]  = bus1.b_rvalid;
    assign a_rd_s[0]  = bus0.a_rdata;  assign a_rd_s[1]  = bus1.a_rdata;
    assign b_rd_s[0]  = bus0.b_rdata;  assign b_rd_s[1]  = bus1.b_rdata;
    assign rom_a_s[0] = bus0.rom_addr; assign rom_a_s[1] = bus1.rom_addr;

    // Behavioural 8K x 8 ROM with one-cycle registered read, one per instance
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) bus0.rom_q <= mem[bus0.rom_addr];
    always @(posedge clk) bus1.rom_q <= mem[bus1.rom_addr];

    // Scoreboard: queue index = inst*2 + port (0 = A, 1 = B)
    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;
    exp_t sb_q[4][$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic ok, int act, int exp);
        n_checks++;
        if (ok === 1'b1) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare every rvalid against the front of its queue, flag lost returns
    logic              mon_v;
    logic [DATA_W-1:0] mon_d;
    exp_t              mon_e;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                mon_v = (p == 1) ? b_rv_s[i] : a_rv_s[i];
                mon_d = (p == 1) ? b_rd_s[i] : a_rd_s[i];
                if (mon_v === 1'b1) begin
                    if (sb_q[i*2+p].size() == 0) begin
                        check($sformatf("unexpected_rvalid inst%0d port%s", i, p ? "B" : "A"),
                              1'b0, 1, 0);
                    end else begin
                        mon_e = sb_q[i*2+p].pop_front();
                        check($sformatf("rdata inst%0d port%s", i, p ? "B" : "A"),
                              mon_d == mon_e.data, mon_d, mon_e.data);
                        check($sformatf("latency inst%0d port%s", i, p ? "B" : "A"),
                              cyc == mon_e.due, cyc, mon_e.due);
                    end
                end else if (sb_q[i*2+p].size() != 0 && sb_q[i*2+p][0].due < cyc) begin
                    mon_e = sb_q[i*2+p].pop_front();
                    check($sformatf("missing_rvalid inst%0d port%s", i, p ? "B" : "A"),
                          1'b0, cyc, mon_e.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at negedge: compare acks against expectation and queue the expected return
    task automatic expect_grant(int i, logic ea, logic eb, string tag);
        exp_t e;
        check($sformatf("%s a_ack inst%0d", tag, i), a_ack_s[i] == ea, a_ack_s[i], ea);
        check($sformatf("%s b_ack inst%0d", tag, i), b_ack_s[i] == eb, b_ack_s[i], eb);
        if (ea) begin
            e.data = mem[a_addr_s[i]];
            e.due  = cyc + 2;
            sb_q[i*2].push_back(e);
        end
        if (eb) begin
            e.data = mem[b_addr_s[i]];
            e.due  = cyc + 2;
            sb_q[i*2+1].push_back(e);
        end
    endtask

    task automatic flush_sb();
        for (int q = 0; q < 4; q++) sb_q[q].delete();
    endtask

    task automatic drop_reqs();
        for (int i = 0; i < 2; i++) begin
            a_req_s[i] = 1'b0;
            b_req_s[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_sb();
        drop_reqs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [5:0] t3_b;
    logic [7:0] t4_b;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_req_s[i]  = 1'b0;
            b_req_s[i]  = 1'b0;
            a_addr_s[i] = '0;
            b_addr_s[i] = '0;
        end
        for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = 8'((k * 37 + 11) & 255);
        mem[13'h0010] = 8'h5A;
        mem[13'h1FFF] = 8'hC3;
        mem[13'h0000] = 8'h3C;
        tick();
        // Reset state
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst a_rvalid inst%0d", i), a_rv_s[i] == 1'b0, a_rv_s[i], 0);
            check($sformatf("rst b_rdata inst%0d", i), b_rd_s[i] == 8'h00, b_rd_s[i], 0);
            check($sformatf("rst rom_addr inst%0d", i), rom_a_s[i] == 13'h0000, rom_a_s[i], 0);
        end
        tick();
        rst = 1'b0;

        // A alone reads 0x0010 on both instances
        for (int i = 0; i < 2; i++) begin
            a_req_s[i]  = 1'b1;
            a_addr_s[i] = 13'h0010;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) expect_grant(i, 1'b1, 1'b0, "t2");
        tick();
        drop_reqs();
        repeat (4) tick();

        // Reset asserted mid-clock with requests pending: outputs clear at once
        #2;
        rst = 1'b1;
        flush_sb();
        for (int i = 0; i < 2; i++) begin
            a_req_s[i]  = 1'b1;
            b_req_s[i]  = 1'b1;
            a_addr_s[i] = 13'h0040;
            b_addr_s[i] = 13'h0041;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t1 a_rdata inst%0d", i), a_rd_s[i] == 8'h00, a_rd_s[i], 0);
            check($sformatf("t1 rom_addr inst%0d", i), rom_a_s[i] == 13'h0000, rom_a_s[i], 0);
            check($sformatf("t1 a_ack inst%0d", i), a_ack_s[i] == 1'b0, a_ack_s[i], 0);
        end
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) expect_grant(i, 1'b1, 1'b0, "t1_first");
        tick();
        drop_reqs();
        repeat (3) tick();

        // Round-robin, both held 6 cycles on inst 0: A,B,A,B,A,B
        do_reset();
        t3_b = 6'b101010;
        a_req_s[0]  = 1'b1;
        b_req_s[0]  = 1'b1;
        a_addr_s[0] = 13'h0100;
        b_addr_s[0] = 13'h0200;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            expect_grant(0, ~t3_b[k], t3_b[k], $sformatf("t3_c%0d", k));
            tick();
            if (t3_b[k]) b_addr_s[0] = b_addr_s[0] + 13'd1;
            else         a_addr_s[0] = a_addr_s[0] + 13'd1;
        end
        drop_reqs();
        repeat (3) tick();

        // Fixed priority, both held 8 cycles on inst 1: A,A,A,B,A,A,A,B
        t4_b = 8'b1000_1000;
        a_req_s[1]  = 1'b1;
        b_req_s[1]  = 1'b1;
        a_addr_s[1] = 13'h0300;
        b_addr_s[1] = 13'h0400;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k > 0 && t4_b[k-1])
                check($sformatf("t4 b_wait_after_B_c%0d", k), dut1.b_wait_q == 4'd0,
                      dut1.b_wait_q, 0);
            expect_grant(1, ~t4_b[k], t4_b[k], $sformatf("t4_c%0d", k));
            tick();
            if (t4_b[k]) b_addr_s[1] = b_addr_s[1] + 13'd1;
            else         a_addr_s[1] = a_addr_s[1] + 13'd1;
        end
        drop_reqs();
        repeat (3) tick();

        // A back-to-back across the address wrap: 0x1FFF then 0x0000
        for (int i = 0; i < 2; i++) begin
            a_req_s[i]  = 1'b1;
            a_addr_s[i] = 13'h1FFF;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) expect_grant(i, 1'b1, 1'b0, "t5_first");
        tick();
        for (int i = 0; i < 2; i++) a_addr_s[i] = 13'h0000;
        @(negedge clk);
        for (int i = 0; i < 2; i++) expect_grant(i, 1'b1, 1'b0, "t5_second");
        tick();
        drop_reqs();
        repeat (4) tick();

        // Reset pulsed the cycle after an ack: that access must never return
        for (int i = 0; i < 2; i++) begin
            a_req_s[i]  = 1'b1;
            a_addr_s[i] = 13'h0020;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) expect_grant(i, 1'b1, 1'b0, "t6_pre");
        tick();
        drop_reqs();
        rst = 1'b1;
        flush_sb();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            a_req_s[i]  = 1'b1;
            a_addr_s[i] = 13'h0010;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) expect_grant(i, 1'b1, 1'b0, "t6_post");
        tick();
        drop_reqs();
        repeat (4) tick();

        // Every queued return must have been delivered
        for (int q = 0; q < 4; q++)
            check($sformatf("drain queue%0d", q), sb_q[q].size() == 0, sb_q[q].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
